// File: rtl/sprite_compositor.sv
// sprite_compositor: 3-stage pipelined compositor for NUM_SPR sprite slots.
// Ports:
//    clk_vga, rst_n             pixel clock and async active-low reset
//    x_ptr, y_ptr, pix_valid    current pixel
//    spr_x, spr_y, spr_en       packed sprite positions and enables
//    frame_tick                 per-frame animation step
//    vis_clr/vis_shift/vis_kill visibility register controls
//    rom_addr, rom_data         shared synchronous sprite ROM
//    rgb, rgb_valid             composited pixel
//    hit_id, hit_valid          winning slot and opaque-hit flag
//    vis                        visibility register
module sprite_compositor #(
   parameter int NUM_SPR = 8,
   parameter int IDW = 3,
   parameter int SPR_W = 20,
   parameter int SPR_H = 20,
   parameter int ANIM_FRAMES = 4,
   parameter logic [NUM_SPR-1:0] ANIM_MASK = 8'h01,
   parameter int ADDR_W = 13,
   parameter logic [7:0] TRANSPARENT = 8'hFF,
   parameter logic [7:0] BG_COLOR = 8'h00,
   parameter logic [NUM_SPR-1:0] VIS_INIT = '1
) (
   input  logic                  clk_vga,
   input  logic                  rst_n,
   input  logic [9:0]            x_ptr,
   input  logic [9:0]            y_ptr,
   input  logic                  pix_valid,
   input  logic [NUM_SPR*10-1:0] spr_x,
   input  logic [NUM_SPR*10-1:0] spr_y,
   input  logic [NUM_SPR-1:0]    spr_en,
   input  logic                  frame_tick,
   input  logic                  vis_clr,
   input  logic                  vis_shift,
   input  logic [NUM_SPR-1:0]    vis_kill,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [7:0]            rom_data,
   output logic [7:0]            rgb,
   output logic                  rgb_valid,
   output logic [IDW-1:0]        hit_id,
   output logic                  hit_valid,
   output logic [NUM_SPR-1:0]    vis
);

   localparam int FW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam int FRAME_SZ = SPR_W * SPR_H;
   localparam int SLOT_SZ = ANIM_FRAMES * FRAME_SZ;

   logic [NUM_SPR-1:0] hit;
   logic [IDW-1:0]     win_id;
   logic               any_hit;
   logic [9:0]         sel_x, sel_y, dx, dy;
   logic [FW-1:0]      frame_cnt, f_sel;
   logic [ADDR_W-1:0]  addr_d;

   logic [IDW-1:0] s1_id, s2_id;
   logic           s1_hit, s2_hit, s1_vld, s2_vld;

   // Bounds use 11-bit sums so sprites near the right/bottom edge don't wrap.
   for (genvar i = 0; i < NUM_SPR; i++) begin : g_hit
      logic [10:0] xi, yi;
      assign xi = {1'b0, spr_x[10*i +: 10]};
      assign yi = {1'b0, spr_y[10*i +: 10]};
      assign hit[i] = spr_en[i] & vis[i] & pix_valid
                    & ({1'b0, x_ptr} >= xi)
                    & ({1'b0, x_ptr} <= xi + 11'(SPR_W - 1))
                    & ({1'b0, y_ptr} >= yi)
                    & ({1'b0, y_ptr} <= yi + 11'(SPR_H - 1));
   end

   // Lowest index wins: scan downward so the last assignment is the lowest.
   always_comb begin
      win_id = '0;
      any_hit = 1'b0;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (hit[i]) begin
            win_id = IDW'(i);
            any_hit = 1'b1;
         end
      end
   end

   always_comb begin
      sel_x = spr_x[win_id*10 +: 10];
      sel_y = spr_y[win_id*10 +: 10];
      dx = x_ptr - sel_x;
      dy = y_ptr - sel_y;
      f_sel = ANIM_MASK[win_id] ? frame_cnt : '0;
      addr_d = ADDR_W'(win_id) * ADDR_W'(SLOT_SZ)
             + ADDR_W'(f_sel) * ADDR_W'(FRAME_SZ)
             + ADDR_W'(dy) * ADDR_W'(SPR_W)
             + ADDR_W'(dx);
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         if (frame_cnt == FW'(ANIM_FRAMES - 1)) frame_cnt <= '0;
         else frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // Clear dominates; kill applies to post-shift bit positions.
   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         vis <= VIS_INIT;
      end else if (vis_clr) begin
         vis <= '0;
      end else if (vis_shift) begin
         vis <= {1'b1, vis[NUM_SPR-1:1]} & ~vis_kill;
      end else begin
         vis <= vis & ~vis_kill;
      end
   end

   always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= '0;
         s1_id <= '0;
         s1_hit <= 1'b0;
         s1_vld <= 1'b0;
         s2_id <= '0;
         s2_hit <= 1'b0;
         s2_vld <= 1'b0;
         rgb <= BG_COLOR;
         rgb_valid <= 1'b0;
         hit_id <= '0;
         hit_valid <= 1'b0;
      end else begin
         rom_addr <= any_hit ? addr_d : '0;
         s1_id <= win_id;
         s1_hit <= any_hit;
         s1_vld <= pix_valid;
         s2_id <= s1_id;
         s2_hit <= s1_hit;
         s2_vld <= s1_vld;
         // A transparent winner shows background, not the next slot.
         if (s2_hit && rom_data != TRANSPARENT) begin
            rgb <= rom_data;
            hit_valid <= 1'b1;
         end else begin
            rgb <= BG_COLOR;
            hit_valid <= 1'b0;
         end
         rgb_valid <= s2_vld;
         hit_id <= s2_id;
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed checks of sprite_compositor.
// Behavioural ROM model; expected values are hand-computed constants.
module tb_sprite_compositor;

   logic        clk_vga = 1'b0;
   logic        rst_n;
   logic [9:0]  x_ptr, y_ptr;
   logic        pix_valid;
   logic [79:0] spr_x, spr_y;
   logic [7:0]  spr_en;
   logic        frame_tick, vis_clr, vis_shift;
   logic [7:0]  vis_kill;
   logic [12:0] rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  rgb;
   logic        rgb_valid;
   logic [2:0]  hit_id;
   logic        hit_valid;
   logic [7:0]  vis;

   int total = 0;
   int bad = 0;
   logic [12:0] a;

   logic [7:0] rom [0:8191];

   always #5 clk_vga = ~clk_vga;

   always @(posedge clk_vga) rom_data <= rom[rom_addr];

   sprite_compositor dut (
      .clk_vga(clk_vga), .rst_n(rst_n),
      .x_ptr(x_ptr), .y_ptr(y_ptr), .pix_valid(pix_valid),
      .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
      .frame_tick(frame_tick), .vis_clr(vis_clr),
      .vis_shift(vis_shift), .vis_kill(vis_kill),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .rgb(rgb), .rgb_valid(rgb_valid),
      .hit_id(hit_id), .hit_valid(hit_valid), .vis(vis)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_vga);
      #1;
   endtask

   task automatic set_spr(input int i, input int x, input int y);
      spr_x[10*i +: 10] = 10'(x);
      spr_y[10*i +: 10] = 10'(y);
   endtask

   // One valid pixel, then idle until its result reaches rgb.
   task automatic run_pix(input int x, input int y, output logic [12:0] ra);
      x_ptr = 10'(x);
      y_ptr = 10'(y);
      pix_valid = 1'b1;
      tick();
      ra = rom_addr;
      pix_valid = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) rom[i] = 8'(i) ^ 8'h5A;
      rom[3265] = 8'h1C;
      rst_n = 1'b0;
      x_ptr = '0; y_ptr = '0; pix_valid = 1'b0;
      spr_en = 8'hFF;
      frame_tick = 1'b0; vis_clr = 1'b0; vis_shift = 1'b0; vis_kill = '0;
      for (int i = 0; i < 8; i++) set_spr(i, 900, 460);
      set_spr(0, 0, 0);
      set_spr(2, 100, 50);
      #23;
      chk("rst_rgb", 32'(rgb), 32'h00);
      chk("rst_rgbv", 32'(rgb_valid), 0);
      chk("rst_hid", 32'(hit_id), 0);
      chk("rst_hv", 32'(hit_valid), 0);
      chk("rst_vis", 32'(vis), 32'hFF);
      chk("rst_addr", 32'(rom_addr), 0);
      rst_n = 1'b1;
      tick();

      run_pix(105, 53, a);
      chk("s2_addr", 32'(a), 3265);
      chk("s2_rgb", 32'(rgb), 32'h1C);
      chk("s2_hid", 32'(hit_id), 2);
      chk("s2_hv", 32'(hit_valid), 1);
      chk("s2_rgbv", 32'(rgb_valid), 1);

      set_spr(1, 200, 200);
      set_spr(4, 200, 200);
      run_pix(210, 210, a);
      chk("ovl_hid", 32'(hit_id), 1);
      chk("ovl_addr", 32'(a), 1810);
      spr_en[1] = 1'b0;
      run_pix(210, 210, a);
      chk("ovl4_hid", 32'(hit_id), 4);
      chk("ovl4_addr", 32'(a), 6610);
      spr_en[1] = 1'b1;
      set_spr(1, 900, 460);
      set_spr(4, 900, 460);

      rom[3265] = 8'hFF;
      run_pix(105, 53, a);
      chk("tr_rgb", 32'(rgb), 32'h00);
      chk("tr_hv", 32'(hit_valid), 0);
      chk("tr_rgbv", 32'(rgb_valid), 1);
      chk("tr_hid", 32'(hit_id), 2);
      rom[3265] = 8'h1C;

      set_spr(1, 300, 300);
      for (int k = 0; k < 5; k++) begin
         run_pix(0, 0, a);
         chk($sformatf("anim0_%0d", k), 32'(a), 32'((k % 4) * 400));
         run_pix(300, 300, a);
         chk($sformatf("anim1_%0d", k), 32'(a), 1600);
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
      end
      set_spr(1, 900, 460);

      vis_kill = 8'hFA;
      tick();
      chk("vis_k", 32'(vis), 32'h05);
      vis_kill = 8'h01;
      vis_shift = 1'b1;
      tick();
      chk("vis_sk", 32'(vis), 32'h82);
      vis_kill = 8'h00;
      vis_clr = 1'b1;
      tick();
      chk("vis_clr", 32'(vis), 32'h00);
      run_pix(105, 53, a);
      chk("inv_hv", 32'(hit_valid), 0);
      chk("inv_rgb", 32'(rgb), 32'h00);
      vis_clr = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      vis_shift = 1'b0;
      chk("vis_fill", 32'(vis), 32'hFF);

      set_spr(3, 1015, 100);
      run_pix(1023, 105, a);
      chk("edge_hid", 32'(hit_id), 3);
      chk("edge_addr", 32'(a), 4908);
      chk("edge_hv", 32'(hit_valid), 1);
      run_pix(0, 105, a);
      chk("wrap_addr", 32'(a), 0);
      chk("wrap_hv", 32'(hit_valid), 0);
      chk("wrap_rgbv", 32'(rgb_valid), 1);

      vis_kill = 8'h81;
      tick();
      vis_kill = 8'h00;
      x_ptr = 10'd105;
      y_ptr = 10'd53;
      pix_valid = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rgbv", 32'(rgb_valid), 0);
      chk("mid_rgb", 32'(rgb), 32'h00);
      chk("mid_addr", 32'(rom_addr), 0);
      chk("mid_vis", 32'(vis), 32'hFF);
      chk("mid_hv", 32'(hit_valid), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rel1_rgbv", 32'(rgb_valid), 0);
      tick();
      chk("rel2_rgbv", 32'(rgb_valid), 0);
      tick();
      chk("rel3_rgbv", 32'(rgb_valid), 1);
      chk("rel3_rgb", 32'(rgb), 32'h1C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
